// File: rtl/countdown_timer_pkg.sv
// Shared definitions for the countdown timer.
//   timer_state_t : controller states (IDLE, RUN, PAUSE, DONE)
package countdown_timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } timer_state_t;

endpackage

// File: rtl/countdown_timer_tick_gen.sv
// tick_gen: prescaler for the countdown timer.
// Counts 0..PRESCALE-1 while ena is high and raises tick in the cycle
// whose edge wraps the counter back to 0. The counter holds its value while
// ena is low, so a paused timer resumes mid-period.
//   clk   in  system clock, rising edge
//   rst_  in  asynchronous active-low reset
//   ena   in  advance the prescaler this cycle
//   clr   in  force the prescaler to 0 (wins over ena)
//   tick  out wrap indication, combinational from the counter and ena
module tick_gen #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst_,
  input  logic ena,
  input  logic clr,
  output logic tick
);

  // A one-cycle prescaler still needs a 1-bit counter to keep the code uniform.
  localparam int CW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [CW-1:0] LAST = CW'(PRESCALE - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    tick  = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (ena) begin
      if (cnt_q == LAST) begin
        cnt_d = '0;
        tick  = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/countdown_timer.sv
// countdown_timer: loadable down-counter with one-shot / periodic modes.
//   clk       in   system clock, rising edge
//   rst_      in   asynchronous active-low reset
//   load      in   pulse: load load_val into count and reload register
//   load_val  in   count / reload value (WIDTH bits)
//   start     in   pulse: begin or resume counting (ignored when count is 0)
//   stop      in   pulse: pause counting (wins over start)
//   mode      in   0 = one-shot, 1 = periodic; sampled on each expiry
//   irq_ack   in   clears irq (a simultaneous expiry keeps it set)
//   count     out  current count value
//   running   out  high exactly while in RUN
//   expired   out  one-cycle pulse following each expiry
//   irq       out  sticky expiry flag
// All outputs come straight from flops.
module countdown_timer
  import countdown_timer_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int PRESCALE = 1
) (
  input  logic             clk,
  input  logic             rst_,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             mode,
  input  logic             irq_ack,
  output logic [WIDTH-1:0] count,
  output logic             running,
  output logic             expired,
  output logic             irq
);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  timer_state_t     state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] reload_q, reload_d;
  logic             running_q, running_d;
  logic             expired_q, expired_d;
  logic             irq_q, irq_d;
  logic             tick;

  // The prescaler advances in every RUN cycle, including the cycle in which
  // stop is sampled; it is frozen from the first PAUSE cycle onwards.
  tick_gen #(
    .PRESCALE (PRESCALE)
  ) u_tick_gen (
    .clk  (clk),
    .rst_ (rst_),
    .ena  ((state_q == RUN) && !load),
    .clr  (load),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    reload_d  = reload_q;
    expired_d = 1'b0;
    irq_d     = irq_q & ~irq_ack;

    if (load) begin
      count_d  = load_val;
      reload_d = load_val;
      state_d  = IDLE;
    end else begin
      case (state_q)
        RUN: begin
          if (tick) begin
            if (count_q > ONE) begin
              count_d = count_q - ONE;
            end else if (count_q == ONE) begin
              expired_d = 1'b1;
              irq_d     = 1'b1;   // set beats a coincident irq_ack
              if (mode) begin
                count_d = reload_q;
              end else begin
                count_d = '0;
                state_d = DONE;
              end
            end
          end
          // A one-shot that expires on the stop cycle finishes in DONE:
          // there is nothing left to pause.
          if (stop && (state_d == RUN)) begin
            state_d = PAUSE;
          end
        end
        default: begin
          if (start && !stop && (count_q != '0)) begin
            state_d = RUN;
          end
        end
      endcase
    end

    running_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_) begin
    if (!rst_) begin
      state_q   <= IDLE;
      count_q   <= '0;
      reload_q  <= '0;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      irq_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      reload_q  <= reload_d;
      running_q <= running_d;
      expired_q <= expired_d;
      irq_q     <= irq_d;
    end
  end

  assign count   = count_q;
  assign running = running_q;
  assign expired = expired_q;
  assign irq     = irq_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Testbench for countdown_timer. Two instances share clk/rst_:
//   dut 0: WIDTH 8, PRESCALE 1    dut 1: WIDTH 8, PRESCALE 4
// Stimulus pushes expected output snapshots (tagged with the edge number)
// and expected expiry pulses into queues; a monitor on the falling edge
// pops and compares them against the outputs.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst_;
  logic       ld  [2];
  logic [7:0] lv  [2];
  logic       st  [2];
  logic       sp  [2];
  logic       md  [2];
  logic       ack [2];
  logic [7:0] cnt_o [2];
  logic       run_o [2];
  logic       exp_o [2];
  logic       irq_o [2];

  always #5 clk = ~clk;

  int unsigned cyc = 0;   // number of rising edges seen so far
  always @(posedge clk) cyc <= cyc + 1;

  countdown_timer #(.WIDTH(8), .PRESCALE(1)) u_dut0 (
    .clk(clk), .rst_(rst_), .load(ld[0]), .load_val(lv[0]), .start(st[0]),
    .stop(sp[0]), .mode(md[0]), .irq_ack(ack[0]), .count(cnt_o[0]),
    .running(run_o[0]), .expired(exp_o[0]), .irq(irq_o[0])
  );

  countdown_timer #(.WIDTH(8), .PRESCALE(4)) u_dut1 (
    .clk(clk), .rst_(rst_), .load(ld[1]), .load_val(lv[1]), .start(st[1]),
    .stop(sp[1]), .mode(md[1]), .irq_ack(ack[1]), .count(cnt_o[1]),
    .running(run_o[1]), .expired(exp_o[1]), .irq(irq_o[1])
  );

  typedef struct {
    int unsigned cyc;
    int          dut;
    logic [7:0]  count;
    logic        running;
    logic        expired;
    logic        irq;
    string       name;
  } rec_t;

  typedef struct {
    int unsigned cyc;
    int          dut;
  } xrec_t;

  rec_t  sb_q[$];
  xrec_t xq[$];
  int    n_cmp = 0;
  int    n_bad = 0;

  function automatic void push(input int unsigned c, input int d, input logic [7:0] cnt,
                               input logic run, input logic ex, input logic irq, input string nm);
    rec_t r;
    r.cyc = c; r.dut = d; r.count = cnt; r.running = run; r.expired = ex; r.irq = irq; r.name = nm;
    sb_q.push_back(r);
  endfunction

  function automatic void push_exp(input int unsigned c, input int d);
    xrec_t x;
    x.cyc = c; x.dut = d;
    xq.push_back(x);
  endfunction

  // Monitor: snapshot scoreboard plus expiry-pulse scoreboard.
  rec_t        mr;
  xrec_t       mx;
  logic [10:0] act_v, exp_v;
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      mr = sb_q.pop_front();
      n_cmp++;
      if (mr.cyc != cyc) begin
        n_bad++;
        $display("FAIL %s dut%0d: snapshot for edge %0d missed, now edge %0d",
                 mr.name, mr.dut, mr.cyc, cyc);
      end else begin
        act_v = {cnt_o[mr.dut], run_o[mr.dut], exp_o[mr.dut], irq_o[mr.dut]};
        exp_v = {mr.count, mr.running, mr.expired, mr.irq};
        if (act_v !== exp_v) begin
          n_bad++;
          $display("FAIL %s dut%0d edge %0d: got count=%0d run=%b exp=%b irq=%b, want count=%0d run=%b exp=%b irq=%b",
                   mr.name, mr.dut, cyc, cnt_o[mr.dut], run_o[mr.dut], exp_o[mr.dut], irq_o[mr.dut],
                   mr.count, mr.running, mr.expired, mr.irq);
        end
      end
    end
    while (xq.size() > 0 && xq[0].cyc < cyc) begin
      mx = xq.pop_front();
      n_cmp++;
      n_bad++;
      $display("FAIL expiry dut%0d: no expired pulse at edge %0d, want 1", mx.dut, mx.cyc);
    end
    for (int d = 0; d < 2; d++) begin
      if (exp_o[d] === 1'b1) begin
        n_cmp++;
        if (xq.size() > 0 && xq[0].cyc == cyc && xq[0].dut == d) begin
          mx = xq.pop_front();
        end else begin
          n_bad++;
          $display("FAIL expiry dut%0d: unexpected expired=1 at edge %0d, want 0", d, cyc);
        end
      end
    end
  end

  int unsigned e, k, r;
  logic [7:0]  ec;

  initial begin
    rst_ = 1'b0;
    for (int d = 0; d < 2; d++) begin
      ld[d] = 0; lv[d] = '0; st[d] = 0; sp[d] = 0; md[d] = 0; ack[d] = 0;
    end
    push(2, 0, 8'd0, 0, 0, 0, "reset_state");
    push(2, 1, 8'd0, 0, 0, 0, "reset_state");
    repeat (3) @(negedge clk);
    rst_ = 1'b1;

    // One-shot, PRESCALE 1: load 3 -> 3,2,1,0, expired after count 1.
    @(negedge clk); e = cyc;
    ld[0] = 1; lv[0] = 8'd3; md[0] = 0;
    push(e + 1, 0, 8'd3, 0, 0, 0, "oneshot_load");
    @(negedge clk);
    ld[0] = 0; st[0] = 1;
    push(e + 2, 0, 8'd3, 1, 0, 0, "oneshot_run");
    push(e + 3, 0, 8'd2, 1, 0, 0, "oneshot_cnt2");
    push(e + 4, 0, 8'd1, 1, 0, 0, "oneshot_cnt1");
    push(e + 5, 0, 8'd0, 0, 1, 1, "oneshot_expire");
    push(e + 6, 0, 8'd0, 0, 0, 1, "oneshot_done");
    push_exp(e + 5, 0);
    @(negedge clk); st[0] = 0;
    repeat (5) @(negedge clk);

    // Corner cases on dut 0 (irq still set from the one-shot).
    e = cyc;
    ld[0] = 1; lv[0] = 8'd0;
    push(e + 1, 0, 8'd0, 0, 0, 1, "load_keeps_irq");
    @(negedge clk); ld[0] = 0; st[0] = 1;
    push(e + 2, 0, 8'd0, 0, 0, 1, "start_count_zero");
    @(negedge clk); ld[0] = 1; lv[0] = 8'd7; st[0] = 1;
    push(e + 3, 0, 8'd7, 0, 0, 1, "load_plus_start");
    @(negedge clk); ld[0] = 0; st[0] = 1; sp[0] = 1;
    push(e + 4, 0, 8'd7, 0, 0, 1, "start_stop_idle");
    @(negedge clk); st[0] = 0; sp[0] = 0; ack[0] = 1;
    push(e + 5, 0, 8'd7, 0, 0, 0, "irq_ack");
    @(negedge clk); ack[0] = 0; st[0] = 1;
    push(e + 6, 0, 8'd7, 1, 0, 0, "run_from_7");
    push(e + 12, 0, 8'd1, 1, 0, 0, "run_cnt1");
    push(e + 13, 0, 8'd0, 0, 1, 1, "ack_vs_expiry");
    push(e + 14, 0, 8'd0, 0, 0, 1, "irq_held");
    push_exp(e + 13, 0);
    @(negedge clk); st[0] = 0;
    repeat (6) @(negedge clk);           // edge e+12
    ack[0] = 1;
    @(negedge clk); ack[0] = 0;          // edge e+13
    @(negedge clk); ack[0] = 1;          // edge e+14
    push(e + 15, 0, 8'd0, 0, 0, 0, "irq_ack_late");
    @(negedge clk); ack[0] = 0;

    // Periodic, PRESCALE 4: load 2 -> 2,1,2,1..., expiry every 8 cycles.
    @(negedge clk); e = cyc;
    ld[1] = 1; lv[1] = 8'd2; md[1] = 1;
    push(e + 1, 1, 8'd2, 0, 0, 0, "periodic_load");
    @(negedge clk); ld[1] = 0; st[1] = 1;
    k = e + 2;
    for (int i = 0; i < 18; i++) begin
      ec = (((i / 4) % 2) == 0) ? 8'd2 : 8'd1;
      push(k + i, 1, ec, 1, (i > 0 && i % 8 == 0), (i >= 8), "periodic");
    end
    push_exp(k + 8, 1);
    push_exp(k + 16, 1);
    @(negedge clk); st[1] = 0;
    repeat (17) @(negedge clk);          // edge k+17
    sp[1] = 1;
    push(k + 18, 1, 8'd2, 0, 0, 1, "periodic_stop");
    @(negedge clk); sp[1] = 0;

    // Pause/resume, PRESCALE 4: load 5, stop two edges after first tick,
    // hold 10 cycles, resume; 20 running cycles to expiry in total.
    @(negedge clk); e = cyc;
    ack[1] = 1; ld[1] = 1; lv[1] = 8'd5; md[1] = 0;
    push(e + 1, 1, 8'd5, 0, 0, 0, "pause_load");
    @(negedge clk); ack[1] = 0; ld[1] = 0; st[1] = 1;
    k = e + 2;
    for (int i = 0; i < 16; i++) begin
      push(k + i, 1, (i < 4) ? 8'd5 : 8'd4, (i < 6), 0, 0, "pause_phase");
    end
    @(negedge clk); st[1] = 0;
    repeat (5) @(negedge clk);           // edge k+5
    sp[1] = 1;
    @(negedge clk); sp[1] = 0;           // edge k+6
    repeat (9) @(negedge clk);           // edge k+15
    st[1] = 1;
    r = k + 16;
    for (int j = 0; j < 16; j++) begin
      ec = (j < 2) ? 8'd4 : (j < 6) ? 8'd3 : (j < 10) ? 8'd2 : (j < 14) ? 8'd1 : 8'd0;
      push(r + j, 1, ec, (j < 14), (j == 14), (j >= 14), "resume_phase");
    end
    push_exp(r + 14, 1);
    @(negedge clk); st[1] = 0;
    repeat (16) @(negedge clk);

    // Reset mid-count: load 200, start, pulse rst_ while count is 100.
    e = cyc;
    ld[1] = 1; lv[1] = 8'd200; md[1] = 0;
    push(e + 1, 1, 8'd200, 0, 0, 1, "rst_load200");
    @(negedge clk); ld[1] = 0; st[1] = 1;
    k = e + 2;
    push(k + 400, 1, 8'd100, 1, 0, 1, "rst_count100");
    @(negedge clk); st[1] = 0;
    repeat (401) @(negedge clk);         // edge k+401
    rst_ = 1'b0;
    @(negedge clk); rst_ = 1'b1;         // edge k+402
    push(k + 403, 0, 8'd0, 0, 0, 0, "after_reset");
    push(k + 403, 1, 8'd0, 0, 0, 0, "after_reset");
    @(negedge clk); st[1] = 1;           // edge k+403
    push(k + 404, 1, 8'd0, 0, 0, 0, "start_after_reset");
    @(negedge clk); st[1] = 0;
    push(k + 410, 1, 8'd0, 0, 0, 0, "quiet_after_reset");
    repeat (10) @(negedge clk);

    if (sb_q.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover_snapshots: %0d pending, want 0", sb_q.size());
    end
    if (xq.size() != 0) begin
      n_cmp++; n_bad++;
      $display("FAIL leftover_expiries: %0d pending, want 0", xq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
